c_samq_credit_tracker: RTL and testbench
========================================

// Module: c_samq_credit_tracker
//
// PURPOSE
//  Upstream (sender-side) flow-control counterpart of a statically allocated
//  multi-queue: tracks, per queue, the free slots (credits) left in the
//  downstream buffer. Debits on each flit sent into a queue, re-credits when the
//  downstream pops that queue, and gives the send allocator availability flags.
//  One instance per output port; queue = VC.
//
// PARAMETERS
//  num_queues           4    number of queues (VCs) tracked
//  num_slots_per_queue  8    downstream buffer entries per queue (N); credits at reset
//  fast_avail           0    1: avail/almost_exhausted flags come from dedicated flops
//                            (early in cycle); 0: decoded from counters
//  enable_bypass        0    1: debit at zero credits is legal if same-queue credit same cycle
//  reset_type           RESET_TYPE_SYNC  fixed for this block
//  derived: cnt_width = clogb(num_slots_per_queue+1)
//
// PORTS
//  clk                 in   1                     clock
//  reset               in   1                     synchronous, active-high
//  debit_active        in   1                     activity indicator, debit side
//  debit_valid         in   1                     flit sent this cycle
//  debit_sel_qu        in   num_queues            one-hot target queue of sent flit
//  credit_active       in   1                     activity indicator, credit side
//  credit_valid        in   1                     credit returned this cycle
//  credit_sel_qu       in   num_queues            one-hot queue the credit belongs to
//  cred_count_qu       out  num_queues*cnt_width  current credits per queue, q0 at MSBs
//  avail_qu            out  num_queues            queue has >=1 credit
//  almost_exhausted_qu out  num_queues            queue has exactly 1 credit
//  all_returned_qu     out  num_queues            queue has N credits (downstream empty)
//  errors_qu           out  num_queues*2          per queue {underflow, overflow}
//
// BEHAVIOUR
//  - Single clock clk; reset synchronous, active-high, wins over all events.
//  - Reset values: cred_count=N, avail=1, almost_exhausted=(N==1), all_returned=1,
//    errors=0, for every queue. Reset mid-operation discards in-flight counts.
//  - debit(q)=debit_valid&debit_sel_qu[q]; credit(q)=credit_valid&credit_sel_qu[q].
//  - Counter update, next cycle (1-cycle latency to all outputs):
//      debit only -> c-1; credit only -> c+1; both or neither -> c.
//  - Counter flop of queue q updates only when (debit_active|credit_active)=1;
//    debit/credit events are only legal with the matching active bit high.
//  - Underflow: debit(q) & c==0 & !(enable_bypass & credit(q)) -> errors[2q]=1
//    same cycle (combinational); counter saturates at 0.
//  - Overflow: credit(q) & !debit(q) & c==N -> errors[2q+1]=1 same cycle;
//    counter saturates at N. errors are not sticky.
//  - enable_bypass=1: debit+credit at c==0 legal, count stays 0, no error.
//  - Flags: avail=(c!=0), almost_exhausted=(c==1), all_returned=(c==N).
//    fast_avail=1: avail/almost_exhausted held in own flops, next-state computed
//    from same inputs; values must equal decoded versions every cycle.
//  - N==1: cnt_width=1; almost_exhausted==avail.
//  - Queues fully independent; events on different queues same cycle both apply.
//
// TESTING  (num_queues=2, N=4 unless noted)
//  1 reset -> counts {4,4}, avail=11, all_returned=11, almost_exhausted=00, errors=0
//  2 4 debits q0 back-to-back -> q0 count 3,2,1,0; almost_exhausted q0 at 1;
//    avail[0]=0 after 4th; 5th debit -> errors[0]=1, count stays 0
//  3 at q0 count 2: debit q0 + credit q0 same cycle -> count 2; debit q0 +
//    credit q1 (q1=3) -> q0=1, q1=4, all_returned[1]=1
//  4 credit q1 at count 4 -> errors[3]=1, count stays 4
//  5 enable_bypass=1, q0 count 0: debit+credit q0 -> no error, count 0;
//    enable_bypass=0 same stimulus -> errors[0]=1
//  6 reset asserted with q0=1,q1=2 and debit pending -> next cycle both 4, no
//    errors; fast_avail=1 and 0 random run -> flags identical to decoded counts

Source files
------------

// File: rtl/c_samq_credit_tracker.sv
// Sender-side credit tracker for a statically partitioned multi-queue buffer:
// one saturating credit counter per queue plus availability/error flags.
module c_samq_credit_tracker #(
  parameter int num_queues          = 4,
  parameter int num_slots_per_queue = 8,
  parameter bit fast_avail          = 1'b0,
  parameter bit enable_bypass       = 1'b0,
  localparam int cnt_width          = $clog2(num_slots_per_queue + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            debit_active,
  input  logic                            debit_valid,
  input  logic [num_queues-1:0]           debit_sel_qu,
  input  logic                            credit_active,
  input  logic                            credit_valid,
  input  logic [num_queues-1:0]           credit_sel_qu,
  output logic [num_queues*cnt_width-1:0] cred_count_qu,
  output logic [num_queues-1:0]           avail_qu,
  output logic [num_queues-1:0]           almost_exhausted_qu,
  output logic [num_queues-1:0]           all_returned_qu,
  output logic [num_queues*2-1:0]         errors_qu
);

  localparam logic [cnt_width-1:0] cnt_max = cnt_width'(num_slots_per_queue);
  localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

  logic upd_en;
  assign upd_en = debit_active | credit_active;

  // Debit and credit together cancel; single events saturate at 0 and N.
  function automatic logic [cnt_width-1:0] sat_update(input logic [cnt_width-1:0] c,
                                                      input logic deb,
                                                      input logic cred);
    logic [cnt_width-1:0] r;
    r = c;
    if (deb && !cred && (c != '0))
      r = c - cnt_one;
    else if (cred && !deb && (c != cnt_max))
      r = c + cnt_one;
    return r;
  endfunction

  for (genvar q = 0; q < num_queues; q++) begin : g_queue
    logic                 deb;
    logic                 cred;
    logic [cnt_width-1:0] cnt_nxt;
    logic [cnt_width-1:0] cnt_p1;

    assign deb     = debit_valid & debit_sel_qu[q];
    assign cred    = credit_valid & credit_sel_qu[q];
    assign cnt_nxt = sat_update(cnt_p1, deb, cred);

    // Stage p1: registered credit count
    always_ff @(posedge clk) begin
      if (reset)
        cnt_p1 <= cnt_max;
      else if (upd_en)
        cnt_p1 <= cnt_nxt;
    end

    // Queue 0 occupies the most significant field.
    assign cred_count_qu[(num_queues-q)*cnt_width-1 -: cnt_width] = cnt_p1;

    assign errors_qu[2*q]   = !reset & deb & (cnt_p1 == '0) & !(enable_bypass & cred);
    assign errors_qu[2*q+1] = !reset & cred & !deb & (cnt_p1 == cnt_max);

    assign all_returned_qu[q] = (cnt_p1 == cnt_max);

    if (fast_avail) begin : g_fast
      logic avail_p1;
      logic almost_p1;

      // Stage p1: flags precomputed from the counter's next state
      always_ff @(posedge clk) begin
        if (reset) begin
          avail_p1  <= 1'b1;
          almost_p1 <= (num_slots_per_queue == 1);
        end else if (upd_en) begin
          avail_p1  <= (cnt_nxt != '0);
          almost_p1 <= (cnt_nxt == cnt_one);
        end
      end

      assign avail_qu[q]            = avail_p1;
      assign almost_exhausted_qu[q] = almost_p1;
    end else begin : g_decode
      assign avail_qu[q]            = (cnt_p1 != '0);
      assign almost_exhausted_qu[q] = (cnt_p1 == cnt_one);
    end
  end

endmodule

// File: tb/tb_c_samq_credit_tracker.sv
// Bench for c_samq_credit_tracker: three instances (N=4 decoded, N=4 fast+bypass,
// N=1 fast) share stimulus and are checked against a per-queue credit model.
module tb_c_samq_credit_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       debit_active, debit_valid, credit_active, credit_valid;
  logic [1:0] debit_sel_qu, credit_sel_qu;

  logic [5:0] cc0, cc1;
  logic [1:0] cc2;
  logic [1:0] av [3];
  logic [1:0] ae [3];
  logic [1:0] ar [3];
  logic [3:0] er [3];

  int checks = 0;
  int errors = 0;

  int mc [3][2];
  int ns [3] = '{4, 4, 1};
  bit mb [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  c_samq_credit_tracker #(.num_queues(2), .num_slots_per_queue(4), .fast_avail(1'b0),
                          .enable_bypass(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .debit_active(debit_active), .debit_valid(debit_valid), .debit_sel_qu(debit_sel_qu),
    .credit_active(credit_active), .credit_valid(credit_valid), .credit_sel_qu(credit_sel_qu),
    .cred_count_qu(cc0), .avail_qu(av[0]), .almost_exhausted_qu(ae[0]),
    .all_returned_qu(ar[0]), .errors_qu(er[0]));

  c_samq_credit_tracker #(.num_queues(2), .num_slots_per_queue(4), .fast_avail(1'b1),
                          .enable_bypass(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .debit_active(debit_active), .debit_valid(debit_valid), .debit_sel_qu(debit_sel_qu),
    .credit_active(credit_active), .credit_valid(credit_valid), .credit_sel_qu(credit_sel_qu),
    .cred_count_qu(cc1), .avail_qu(av[1]), .almost_exhausted_qu(ae[1]),
    .all_returned_qu(ar[1]), .errors_qu(er[1]));

  c_samq_credit_tracker #(.num_queues(2), .num_slots_per_queue(1), .fast_avail(1'b1),
                          .enable_bypass(1'b0)) dut2 (
    .clk(clk), .reset(reset),
    .debit_active(debit_active), .debit_valid(debit_valid), .debit_sel_qu(debit_sel_qu),
    .credit_active(credit_active), .credit_valid(credit_valid), .credit_sel_qu(credit_sel_qu),
    .cred_count_qu(cc2), .avail_qu(av[2]), .almost_exhausted_qu(ae[2]),
    .all_returned_qu(ar[2]), .errors_qu(er[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_cnt(input int i, input int q);
    logic [31:0] r;
    case (i)
      0:       r = (q == 0) ? {29'b0, cc0[5:3]} : {29'b0, cc0[2:0]};
      1:       r = (q == 0) ? {29'b0, cc1[5:3]} : {29'b0, cc1[2:0]};
      default: r = (q == 0) ? {31'b0, cc2[1]}   : {31'b0, cc2[0]};
    endcase
    return r;
  endfunction

  // One clock: drive, check same-cycle error flags, then check registered state.
  task automatic step(input bit r, input bit dv, input logic [1:0] ds,
                      input bit cv, input logic [1:0] cs, input bit da, input bit ca);
    logic [3:0] exp_err;
    bit d, c;
    @(negedge clk);
    reset = r; debit_valid = dv; debit_sel_qu = ds; credit_valid = cv; credit_sel_qu = cs;
    debit_active = da; credit_active = ca;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_err = '0;
      for (int q = 0; q < 2; q++) begin
        d = dv && ds[q];
        c = cv && cs[q];
        if (!r) begin
          exp_err[2*q]   = d && (mc[i][q] == 0) && !(mb[i] && c);
          exp_err[2*q+1] = c && !d && (mc[i][q] == ns[i]);
        end
      end
      chk($sformatf("errors_i%0d", i), {28'b0, er[i]}, {28'b0, exp_err});
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      for (int q = 0; q < 2; q++) begin
        d = dv && ds[q];
        c = cv && cs[q];
        if (r) mc[i][q] = ns[i];
        else if (da || ca) begin
          if (d && !c && mc[i][q] > 0) mc[i][q]--;
          else if (c && !d && mc[i][q] < ns[i]) mc[i][q]++;
        end
      end
    #1;
    for (int i = 0; i < 3; i++)
      for (int q = 0; q < 2; q++) begin
        chk($sformatf("count_i%0d_q%0d", i, q), get_cnt(i, q), mc[i][q]);
        chk($sformatf("avail_i%0d_q%0d", i, q), {31'b0, av[i][q]}, {31'b0, mc[i][q] != 0});
        chk($sformatf("almost_i%0d_q%0d", i, q), {31'b0, ae[i][q]}, {31'b0, mc[i][q] == 1});
        chk($sformatf("allret_i%0d_q%0d", i, q), {31'b0, ar[i][q]}, {31'b0, mc[i][q] == ns[i]});
      end
  endtask

  task automatic deb(input logic [1:0] s);
    step(0, 1, s, 0, 2'b00, 1, 0);
  endtask

  initial begin
    bit dv, cv, r;
    logic [1:0] ds, cs;
    for (int i = 0; i < 3; i++) for (int q = 0; q < 2; q++) mc[i][q] = 0;

    // Reset state
    step(1, 0, 2'b00, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 2'b00, 0, 0);
    chk("reset_cc0", {26'b0, cc0}, 32'h24);
    chk("reset_ae2", {30'b0, ae[2]}, 32'h3);

    // Drain q0 and push one past empty
    for (int k = 0; k < 5; k++) deb(2'b01);
    chk("drained_q0", get_cnt(0, 0), 32'd0);

    // Simultaneous same-queue and cross-queue events at q0 == 2
    step(1, 0, 2'b00, 0, 2'b00, 0, 0);
    deb(2'b01); deb(2'b01);
    step(0, 1, 2'b01, 1, 2'b01, 1, 1);
    chk("same_q_cancel", get_cnt(0, 0), 32'd2);
    deb(2'b10);
    step(0, 1, 2'b01, 1, 2'b10, 1, 1);
    chk("cross_q0", get_cnt(0, 0), 32'd1);
    chk("cross_q1", get_cnt(0, 1), 32'd4);

    // Overflow on a full queue
    step(0, 0, 2'b00, 1, 2'b10, 0, 1);

    // Bypass versus no bypass at zero credits
    deb(2'b01);
    step(0, 1, 2'b01, 1, 2'b01, 1, 1);
    chk("bypass_cnt", get_cnt(1, 0), 32'd0);

    // Inactive cycle must hold counts
    step(0, 1, 2'b10, 0, 2'b00, 0, 0);

    // Reset with a pending debit
    step(1, 0, 2'b00, 0, 2'b00, 0, 0);
    deb(2'b01); deb(2'b01); deb(2'b01); deb(2'b10); deb(2'b10);
    step(1, 1, 2'b01, 0, 2'b00, 1, 0);
    chk("rst_mid_cc0", {26'b0, cc0}, 32'h24);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 49) == 0);
      dv = $urandom_range(0, 1);
      cv = $urandom_range(0, 1);
      ds = 2'b01 << $urandom_range(0, 1);
      cs = 2'b01 << $urandom_range(0, 1);
      step(r, dv, ds, cv, cs, dv | ($urandom_range(0, 3) == 0), cv | ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
